lfsr16_prbs_checker: RTL and testbench
======================================

// Module: lfsr16_prbs_checker
// PURPOSE
//  Receive-side companion of the 16-bit serial LFSR generators (taps 15,13,12,10; new bit = feedback, shifted into LSB).
//  Self-synchronises to an incoming 1-bit/cycle PRBS stream, declares lock, then flags and counts bit errors.
//  Declares loss of lock when errors are too dense. Sits at the sink of BIST/link-test datapaths.
// PARAMETERS
//  LOCK_CNT  16  consecutive correct predictions needed after seeding to declare lock (1..255)
//  WINDOW    64  locked-mode observation window, counted in valid bits (2..65535)
//  LOSS_THR   8  errors within one WINDOW that drop lock (1..WINDOW)
//  ERRW      16  width of the saturating error counter
// PORTS
//  clk       in   1     clock, all state updates on rising edge
//  rst       in   1     asynchronous, active-low reset
//  in_vld    in   1     in_bit is valid this cycle; state advances only when in_vld=1
//  in_bit    in   1     received PRBS bit
//  clr_cnt   in   1     synchronous clear of err_cnt
//  locked    out  1     checker is in LOCKED state
//  err_pulse out  1     one-cycle flag: the previous valid bit mismatched while locked
//  err_cnt   out  ERRW  saturating count of locked-mode mismatches
//  state     out  2     FSM state: 0 FILL, 1 VERIFY, 2 LOCKED
// BEHAVIOUR
//  Reset (rst=0): state=FILL, S=16'h0, fill/good/window/window-error counters=0, locked=0, err_pulse=0, err_cnt=0.
//  S[15:0] holds history; pred = ^{S[15],S[13],S[12],S[10]}; mis = in_vld & (in_bit != pred).
//  in_vld=0: no state, counter or S change; err_pulse=0 next cycle.
//  FILL: each valid bit S<={S[14:0],in_bit}; fill_cnt++; after 16th bit -> VERIFY, good=0.
//  VERIFY: S<={S[14:0],in_bit} always. Match: good++; mismatch: good=0.
//    good reaching LOCK_CNT -> LOCKED, visible as locked=1 the cycle after the LOCK_CNT-th matching bit.
//    S==0 (lock-up state) counts as no match: good held at 0 and no lock is declared.
//  LOCKED: flywheel, S<={S[14:0],pred}; errors never enter S.
//    Mismatch: err_pulse=1 next cycle; err_cnt+1 saturating at all-ones; win_err+1.
//    Window: win_bits counts valid bits 0..WINDOW-1. At wrap, win_bits=0 and win_err=0.
//      An error on the wrap bit counts into the closing window.
//    win_err reaching LOSS_THR -> FILL: locked=0 next cycle, fill_cnt=0, S kept but fully reloaded. err_cnt not cleared.
//  clr_cnt=1 wins over an increment in the same cycle: err_cnt <= mis_locked ? 1 : 0.
//  err_cnt counts only in LOCKED; VERIFY mismatches never count.
//  Reset asserted mid-stream: immediate return to reset values. Resync needs 16+LOCK_CNT valid bits.
//  All outputs are registered. Checker latency: 1 cycle from the valid bit to err_pulse/locked.
// STRUCTURE
//  Shared package (struct.v): LFSR16 tap positions and the feedback macro, shared with the generators.
//    Also the FSM encodings PRBS_FILL=2'd0, PRBS_VERIFY=2'd1, PRBS_LOCKED=2'd2.
//  Sub-module lfsr16_loss_window: win_bits/win_err counters plus threshold compare.
//    Inputs step, err, clear; output loss. Instantiated once.
//  Top level holds the FSM, S, the good counter and err_cnt. Target 150-250 lines total.
// TESTING
//  1 Feed LFSR16_1 output, INITVAL 16'he45b, in_vld=1 -> locked=1 exactly 16+16=32 valid bits after the first; err_cnt=0 for 10k bits.
//  2 Locked; invert one bit -> single err_pulse one cycle later, err_cnt=1, no further errors (flywheel); locked stays 1.
//  3 Locked; invert 8 bits inside one 64-bit window -> locked=0, state=FILL after the 8th; relock 32 bits later; err_cnt=8.
//  4 Invert 7 bits in window N and 7 in window N+1 -> lock retained; err_cnt=14.
//  5 Constant-zero input -> never locks; state oscillates no further than VERIFY; err_cnt=0.
//  6 Random in_vld gaps (~50%) -> same lock point in valid bits as test 1.
//  6 (cont.) clr_cnt coincident with an error -> err_cnt=1. Force err_cnt=16'hffff then one error -> stays 16'hffff.
//  6 (cont.) rst pulse mid-lock -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/lfsr16_prbs_checker_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : lfsr16_prbs_checker_pkg
//  Brief    : Shared LFSR16 tap positions, feedback function and checker FSM
//             state encoding (common with the serial LFSR16 generators).
//  Revision : 1.0  initial release
// ============================================================================
package lfsr16_prbs_checker_pkg;

    // Tap positions of the x^16 + x^14 + x^13 + x^11 + 1 polynomial
    localparam int LFSR16_TAP_A = 15;
    localparam int LFSR16_TAP_B = 13;
    localparam int LFSR16_TAP_C = 12;
    localparam int LFSR16_TAP_D = 10;

    typedef enum logic [1:0] {
        PRBS_FILL   = 2'd0,
        PRBS_VERIFY = 2'd1,
        PRBS_LOCKED = 2'd2
    } prbs_state_t;

    // Feedback bit the generator shifts into its LSB next
    function automatic logic lfsr16_fb(input logic [15:0] s);
        return s[LFSR16_TAP_A] ^ s[LFSR16_TAP_B] ^ s[LFSR16_TAP_C] ^ s[LFSR16_TAP_D];
    endfunction

endpackage
`default_nettype wire

// File: rtl/lfsr16_loss_window.sv
`default_nettype none
// ============================================================================
//  Module   : lfsr16_loss_window
//  Brief    : Counts valid bits in a fixed observation window and the errors
//             seen in it; flags loss when the error count reaches LOSS_THR.
//  Revision : 1.0  initial release
// ============================================================================
module lfsr16_loss_window #(
    parameter int WINDOW   = 64,
    parameter int LOSS_THR = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic i_step,
    input  logic i_err,
    input  logic i_clear,
    output logic o_loss
);

    localparam logic [15:0] c_WIN_LAST = 16'(WINDOW - 1);
    localparam logic [15:0] c_THR_M1   = 16'(LOSS_THR - 1);

    logic [15:0] r_bits;
    logic [15:0] r_err;
    logic        w_wrap;

    assign w_wrap = (r_bits == c_WIN_LAST);

    // Loss is decided on the bit itself so the FSM can leave LOCKED on the
    // same edge; the wrap bit still belongs to the closing window.
    assign o_loss = i_step & i_err & (r_err == c_THR_M1);

    // Window position and per-window error accumulation
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_bits <= 16'd0;
            r_err  <= 16'd0;
        end else if (i_clear) begin
            r_bits <= 16'd0;
            r_err  <= 16'd0;
        end else if (i_step) begin
            if (w_wrap) begin
                r_bits <= 16'd0;
                r_err  <= 16'd0;
            end else begin
                r_bits <= r_bits + 16'd1;
                r_err  <= r_err + {15'd0, i_err};
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/lfsr16_prbs_checker.sv
`default_nettype none
// ============================================================================
//  Module   : lfsr16_prbs_checker
//  Brief    : Self-synchronising LFSR16 PRBS receiver: fills history from the
//             line, verifies predictions, then flywheels while locked and
//             counts bit errors; drops lock on dense errors.
//  Revision : 1.0  initial release
// ============================================================================
module lfsr16_prbs_checker
    import lfsr16_prbs_checker_pkg::*;
#(
    parameter int LOCK_CNT = 16,
    parameter int WINDOW   = 64,
    parameter int LOSS_THR = 8,
    parameter int ERRW     = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_vld,
    input  logic            in_bit,
    input  logic            clr_cnt,
    output logic            locked,
    output logic            err_pulse,
    output logic [ERRW-1:0] err_cnt,
    output logic [1:0]      state
);

    localparam logic [7:0]      c_GOOD_LAST = 8'(LOCK_CNT - 1);
    localparam logic [ERRW-1:0] c_ERR_MAX   = {ERRW{1'b1}};

    prbs_state_t     r_state;
    prbs_state_t     w_next_state;
    logic [15:0]     r_s;
    logic [15:0]     w_s_next;
    logic [3:0]      r_fill;
    logic [3:0]      w_fill_next;
    logic [7:0]      r_good;
    logic [7:0]      w_good_next;
    logic            r_locked;
    logic            r_err_pulse;
    logic [ERRW-1:0] r_err_cnt;

    logic            w_pred;
    logic            w_mis;
    logic            w_in_locked;
    logic            w_mis_locked;
    logic            w_loss;

    assign w_pred       = lfsr16_fb(r_s);
    assign w_mis        = in_vld & (in_bit != w_pred);
    assign w_in_locked  = (r_state == PRBS_LOCKED);
    assign w_mis_locked = w_mis & w_in_locked;

    lfsr16_loss_window #(
        .WINDOW   (WINDOW),
        .LOSS_THR (LOSS_THR)
    ) u_loss_window (
        .clk     (clk),
        .rst     (rst),
        .i_step  (in_vld & w_in_locked),
        .i_err   (w_mis),
        .i_clear (~w_in_locked),
        .o_loss  (w_loss)
    );

    // Next-state, history and fill/good counter updates; idle bits change nothing
    always_comb begin
        w_next_state = r_state;
        w_s_next     = r_s;
        w_fill_next  = r_fill;
        w_good_next  = r_good;
        if (in_vld) begin
            case (r_state)
                PRBS_FILL: begin
                    w_s_next = {r_s[14:0], in_bit};
                    if (r_fill == 4'd15) begin
                        w_fill_next  = 4'd0;
                        w_good_next  = 8'd0;
                        w_next_state = PRBS_VERIFY;
                    end else begin
                        w_fill_next = r_fill + 4'd1;
                    end
                end
                PRBS_VERIFY: begin
                    w_s_next = {r_s[14:0], in_bit};
                    // An all-zero history predicts zero forever; never trust it
                    if (!w_mis && (r_s != 16'h0)) begin
                        if (r_good == c_GOOD_LAST) begin
                            w_good_next  = 8'd0;
                            w_next_state = PRBS_LOCKED;
                        end else begin
                            w_good_next = r_good + 8'd1;
                        end
                    end else begin
                        w_good_next = 8'd0;
                    end
                end
                PRBS_LOCKED: begin
                    // Flywheel: line errors never corrupt the history
                    w_s_next = {r_s[14:0], w_pred};
                    if (w_loss) begin
                        w_fill_next  = 4'd0;
                        w_next_state = PRBS_FILL;
                    end
                end
                default: begin
                    w_next_state = PRBS_FILL;
                end
            endcase
        end
    end

    // FSM state, history register and counters
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= PRBS_FILL;
            r_s     <= 16'h0;
            r_fill  <= 4'd0;
            r_good  <= 8'd0;
        end else begin
            r_state <= w_next_state;
            r_s     <= w_s_next;
            r_fill  <= w_fill_next;
            r_good  <= w_good_next;
        end
    end

    // Registered status outputs and saturating error counter (clear wins)
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_locked    <= 1'b0;
            r_err_pulse <= 1'b0;
            r_err_cnt   <= '0;
        end else begin
            r_locked    <= (w_next_state == PRBS_LOCKED);
            r_err_pulse <= w_mis_locked;
            if (clr_cnt) begin
                r_err_cnt <= w_mis_locked ? ERRW'(1) : '0;
            end else if (w_mis_locked && (r_err_cnt != c_ERR_MAX)) begin
                r_err_cnt <= r_err_cnt + ERRW'(1);
            end
        end
    end

    assign locked    = r_locked;
    assign err_pulse = r_err_pulse;
    assign err_cnt   = r_err_cnt;
    assign state     = r_state;

endmodule
`default_nettype wire

// File: tb/tb_lfsr16_prbs_checker.sv
`default_nettype none
// ============================================================================
//  Module   : tb_lfsr16_prbs_checker
//  Brief    : Directed self-checking bench for lfsr16_prbs_checker.
//  Revision : 1.0  initial release
// ============================================================================
module tb_lfsr16_prbs_checker;

    logic        clk;
    logic        rst_n;
    logic        in_vld;
    logic        in_bit;
    logic        clr_cnt;
    logic        locked;
    logic        err_pulse;
    logic [15:0] err_cnt;
    logic [1:0]  state;
    logic        locked2;
    logic        err_pulse2;
    logic [2:0]  err_cnt2;
    logic [1:0]  state2;

    int          n_chk;
    int          n_err;
    int          vcount;
    int          lock_base;
    int          pulse_cnt;
    int          seen_lock;
    int          guard;
    int          pc;
    logic [15:0] g;
    logic        b;

    lfsr16_prbs_checker dut (
        .clk       (clk),
        .rst       (rst_n),
        .in_vld    (in_vld),
        .in_bit    (in_bit),
        .clr_cnt   (clr_cnt),
        .locked    (locked),
        .err_pulse (err_pulse),
        .err_cnt   (err_cnt),
        .state     (state)
    );

    // Narrow counter instance: same stimulus, shows saturation at 3'b111
    lfsr16_prbs_checker #(.ERRW(3)) dut_sat (
        .clk       (clk),
        .rst       (rst_n),
        .in_vld    (in_vld),
        .in_bit    (in_bit),
        .clr_cnt   (clr_cnt),
        .locked    (locked2),
        .err_pulse (err_pulse2),
        .err_cnt   (err_cnt2),
        .state     (state2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Apply one cycle of inputs; return 1 time unit after the active edge
    task automatic drive(input logic v, input logic bit_i, input logic clr);
        in_vld  = v;
        in_bit  = bit_i;
        clr_cnt = clr;
        @(posedge clk);
        #1;
        if (v) vcount++;
        if (err_pulse) pulse_cnt++;
    endtask

    // Reference generator: feedback shifted into LSB and emitted
    task automatic gen_bit(output logic fb);
        fb = g[15] ^ g[13] ^ g[12] ^ g[10];
        g  = {g[14:0], fb};
    endtask

    task automatic send_gen(input int n);
        logic x;
        for (int i = 0; i < n; i++) begin
            gen_bit(x);
            drive(1'b1, x, 1'b0);
        end
    endtask

    task automatic send_err(input logic clr);
        logic x;
        gen_bit(x);
        drive(1'b1, ~x, clr);
    endtask

    task automatic send_clr();
        logic x;
        gen_bit(x);
        drive(1'b1, x, 1'b1);
    endtask

    task automatic pad_to_window();
        while (((vcount - lock_base) % 64) != 0) send_gen(1);
    endtask

    initial begin
        n_chk = 0; n_err = 0; vcount = 0; lock_base = 0; pulse_cnt = 0;
        seen_lock = 0;
        rst_n = 1'b0; in_vld = 1'b0; in_bit = 1'b0; clr_cnt = 1'b0;
        g = 16'he45b;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_locked", 32'(locked), 0);
        chk("rst_pulse", 32'(err_pulse), 0);
        chk("rst_errcnt", 32'(err_cnt), 0);
        chk("rst_state", 32'(state), 0);
        rst_n = 1'b1;

        // Acquisition from a clean stream
        send_gen(15);
        chk("fill15_state", 32'(state), 0);
        send_gen(1);
        chk("fill16_state", 32'(state), 1);
        send_gen(15);
        chk("bit31_locked", 32'(locked), 0);
        chk("bit31_state", 32'(state), 1);
        send_gen(1);
        chk("bit32_locked", 32'(locked), 1);
        chk("bit32_state", 32'(state), 2);
        lock_base = vcount;
        pc = pulse_cnt;
        send_gen(10000);
        chk("long_errcnt", 32'(err_cnt), 0);
        chk("long_pulses", 32'(pulse_cnt - pc), 0);
        chk("long_locked", 32'(locked), 1);

        // Single error, flywheel keeps following
        send_err(1'b0);
        chk("single_pulse", 32'(err_pulse), 1);
        chk("single_errcnt", 32'(err_cnt), 1);
        chk("single_locked", 32'(locked), 1);
        send_gen(1);
        chk("single_pulse_off", 32'(err_pulse), 0);
        pc = pulse_cnt;
        send_gen(100);
        chk("single_no_more", 32'(pulse_cnt - pc), 0);
        chk("single_errcnt2", 32'(err_cnt), 1);

        // Eight errors in one window drop lock, then relock
        send_clr();
        chk("clr_errcnt", 32'(err_cnt), 0);
        chk("clr_errcnt_sat", 32'(err_cnt2), 0);
        pad_to_window();
        for (int i = 0; i < 7; i++) begin
            send_err(1'b0);
            send_gen(1);
        end
        chk("err7_locked", 32'(locked), 1);
        chk("err7_errcnt", 32'(err_cnt), 7);
        send_err(1'b0);
        chk("err8_locked", 32'(locked), 0);
        chk("err8_state", 32'(state), 0);
        chk("err8_errcnt", 32'(err_cnt), 8);
        chk("err8_sat", 32'(err_cnt2), 7);
        send_gen(31);
        chk("relock31", 32'(locked), 0);
        send_gen(1);
        chk("relock32", 32'(locked), 1);
        lock_base = vcount;

        // 7 errors ending on the wrap bit, 7 more in the next window
        send_clr();
        pad_to_window();
        send_gen(51);
        for (int i = 0; i < 7; i++) begin
            send_err(1'b0);
            if (i < 6) send_gen(1);
        end
        chk("winN_locked", 32'(locked), 1);
        chk("winN_errcnt", 32'(err_cnt), 7);
        for (int i = 0; i < 7; i++) begin
            send_err(1'b0);
            send_gen(1);
        end
        chk("winN1_locked", 32'(locked), 1);
        chk("winN1_state", 32'(state), 2);
        chk("winN1_errcnt", 32'(err_cnt), 14);
        chk("winN1_sat", 32'(err_cnt2), 7);

        // Clear coincident with an error, idle behaviour
        pad_to_window();
        send_err(1'b1);
        chk("clr_err_errcnt", 32'(err_cnt), 1);
        chk("clr_err_pulse", 32'(err_pulse), 1);
        drive(1'b0, 1'b1, 1'b0);
        chk("idle_pulse", 32'(err_pulse), 0);
        chk("idle_errcnt", 32'(err_cnt), 1);
        chk("idle_locked", 32'(locked), 1);
        drive(1'b0, 1'b0, 1'b1);
        chk("idle_clr", 32'(err_cnt), 0);

        // Asynchronous reset while locked with a pending pulse
        send_err(1'b0);
        chk("pre_rst_pulse", 32'(err_pulse), 1);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_locked", 32'(locked), 0);
        chk("arst_pulse", 32'(err_pulse), 0);
        chk("arst_errcnt", 32'(err_cnt), 0);
        chk("arst_state", 32'(state), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Constant zero never locks
        for (int i = 0; i < 300; i++) begin
            drive(1'b1, 1'b0, 1'b0);
            if (locked || state == 2'd2) seen_lock++;
        end
        chk("zero_seen_lock", 32'(seen_lock), 0);
        chk("zero_state", 32'(state), 1);
        chk("zero_errcnt", 32'(err_cnt), 0);

        // Random valid gaps: lock on the same valid-bit count
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        g = 16'he45b;
        vcount = 0;
        guard = 0;
        while (vcount < 31 && guard < 2000) begin
            guard++;
            if ($urandom_range(0, 1) == 1) begin
                gen_bit(b);
                drive(1'b1, b, 1'b0);
            end else begin
                drive(1'b0, 1'($urandom), 1'b0);
            end
        end
        chk("gap_vcount31", 32'(vcount), 31);
        chk("gap31_locked", 32'(locked), 0);
        drive(1'b0, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 1'b0);
        chk("gap_idle_locked", 32'(locked), 0);
        send_gen(1);
        chk("gap32_locked", 32'(locked), 1);
        chk("gap32_state", 32'(state), 2);
        send_gen(20);
        chk("gap_errcnt", 32'(err_cnt), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
